// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared types and defaults for the DAC share scheduler.
// Optional feature macro used by dac_share_sched: DAC_SCHED_HOLD_EN.
package dac_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dac_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request after last_grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   grant,
  output logic            any
);

  logic [IW:0] cand;

  // Scan last_grant+1 .. last_grant+NREQ (mod NREQ); first hit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!any && req[cand[IW-1:0]]) begin
        grant = cand[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_share_sched.sv
// dac_share_sched: shares one DAC serializer among NREQ sample requesters,
// issuing one frame per sample period with round-robin arbitration.
// Optional feature macro: DAC_SCHED_HOLD_EN (re-send last word on underrun).
module dac_share_sched
  import dac_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int PW   = 16
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    en,
  input  logic [PW-1:0]           period,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           dac_data,
  output logic                    dac_start,
  input  logic                    dac_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int IW = $clog2(NREQ);

  sched_state_t  state_q, state_d;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] p_m1;
  logic          tick;
  logic [IW-1:0] sel_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] arb_grant;
  logic          arb_any;
  logic [DW-1:0] sel_data;
  logic          is_idle;
`ifdef DAC_SCHED_HOLD_EN
  logic          sent_q;
`endif

  // Effective period is max(period,2); a counter that overshoots after a
  // period change wraps on the next cycle instead of running to 2^PW.
  always_comb begin
    p_m1    = (period < PW'(2)) ? PW'(1) : period - PW'(1);
    tick    = en && (cnt_q >= p_m1);
    is_idle = (state_q == ST_IDLE);
  end

  // Period counter: runs while enabled, holds while disabled.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PW'(1);
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  // FSM state register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-state decoded outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    dac_start = 1'b0;
    underrun  = tick && is_idle && !arb_any;
    overrun   = tick && !is_idle;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (arb_any) begin
            state_d = ST_GRANT;
          end
`ifdef DAC_SCHED_HOLD_EN
          else if (sent_q) begin
            state_d = ST_START;
          end
`endif
        end
      end
      ST_GRANT: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          req_ready[i] = (sel_q == IW'(i));
        end
        state_d = ST_START;
      end
      ST_START: begin
        dac_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (dac_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the granted requester's word with constant slices.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_q == IW'(i)) begin
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Grant bookkeeping and DAC word capture.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sel_q    <= '0;
      last_q   <= IW'(NREQ - 1);
      dac_data <= '0;
      grant_id <= '0;
    end else begin
      if (is_idle && tick && arb_any) begin
        sel_q <= arb_grant;
      end
      if (state_q == ST_GRANT) begin
        dac_data <= sel_data;
        grant_id <= sel_q;
        last_q   <= sel_q;
      end
    end
  end

`ifdef DAC_SCHED_HOLD_EN
  // Remember whether dac_data holds a real sample worth re-sending.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sent_q <= 1'b0;
    end else if (state_q == ST_GRANT) begin
      sent_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_share_sched.sv
// tb_dac_share_sched: directed checks of arbitration, frame timing,
// overrun/underrun pulses, period clamping and reset behaviour.
module tb_dac_share_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int PW   = 16;

  logic               aclk = 1'b0;
  logic               areset_n = 1'b0;
  logic               en = 1'b0;
  logic [PW-1:0]      period = '0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      dac_data;
  logic               dac_start;
  logic               dac_done = 1'b0;
  logic [1:0]         grant_id;
  logic               underrun;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rdy = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;

  always #5 aclk = ~aclk;

  dac_share_sched #(
    .NREQ (NREQ),
    .DW   (DW),
    .PW   (PW)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .en        (en),
    .period    (period),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dac_data  (dac_data),
    .dac_start (dac_start),
    .dac_done  (dac_done),
    .grant_id  (grant_id),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  // Count error pulses away from the active edge.
  always @(negedge aclk) begin
    if (overrun)  ovr_cnt++;
    if (underrun) und_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    dac_done = 1'b0;
    step();
    step();
  endtask

  task automatic release_rst();
    areset_n = 1'b1;
    last_rdy = cyc;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (req_ready == '0 && n < limit) begin
      step();
      n++;
    end
    chk("ready_seen", 32'(req_ready != '0), 32'(1));
  endtask

  // One full frame with dac_done returned 5 cycles after dac_start.
  task automatic frame(input int g, input logic [DW-1:0] d);
    int n;
    wait_ready(40, n);
    chk("rr_spacing", 32'(cyc - last_rdy), 32'(10));
    last_rdy = cyc;
    chk("rr_ready", 32'(req_ready), 32'(1) << g);
    step();
    chk("rr_ready_pulse", 32'(req_ready), 32'(0));
    chk("rr_start", 32'(dac_start), 32'(1));
    chk("rr_data", 32'(dac_data), 32'(d));
    chk("rr_gid", 32'(grant_id), 32'(g));
    step();
    chk("rr_start_pulse", 32'(dac_start), 32'(0));
    repeat (4) step();
    chk("rr_data_hold", 32'(dac_data), 32'(d));
    dac_done = 1'b1;
    step();
    dac_done = 1'b0;
  endtask

  initial begin
    int n;
    int ovr0, und0;
    logic [31:0] smask, omask, umask;

    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = DW'(16'h1000 + i);
    end

    // Reset values
    do_reset();
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_start", 32'(dac_start), 32'(0));
    chk("rst_data", 32'(dac_data), 32'(0));
    chk("rst_gid", 32'(grant_id), 32'(0));
    chk("rst_und", 32'(underrun), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));

    // Round-robin over all four requesters, period 10
    period = PW'(10);
    en = 1'b1;
    req_valid = 4'b1111;
    release_rst();
    ovr0 = ovr_cnt;
    und0 = und_cnt;
    frame(0, 16'h1000);
    frame(1, 16'h1001);
    frame(2, 16'h1002);
    frame(3, 16'h1003);
    frame(0, 16'h1000);
    chk("rr_no_ovr", 32'(ovr_cnt - ovr0), 32'(0));
    chk("rr_no_und", 32'(und_cnt - und0), 32'(0));

    // Reset asserted while waiting for dac_done
    wait_ready(40, n);
    chk("rw_ready", 32'(req_ready), 32'b0010);
    step();
    step();
    #2;
    areset_n = 1'b0;
    #1;
    chk("rw_data_clr", 32'(dac_data), 32'(0));
    chk("rw_gid_clr", 32'(grant_id), 32'(0));
    chk("rw_start_clr", 32'(dac_start), 32'(0));
    chk("rw_ready_clr", 32'(req_ready), 32'(0));
    step();
    release_rst();
    frame(0, 16'h1000);

    // Single requester 2
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 16'hA5A5;
    release_rst();
    wait_ready(40, n);
    chk("one_spacing", 32'(cyc - last_rdy), 32'(10));
    chk("one_ready", 32'(req_ready), 32'b0100);
    step();
    chk("one_ready_pulse", 32'(req_ready), 32'(0));
    chk("one_data", 32'(dac_data), 32'hA5A5);
    chk("one_gid", 32'(grant_id), 32'(2));
    chk("one_start", 32'(dac_start), 32'(1));
    req_valid = '0;
    step();
    dac_done = 1'b1;
    step();
    dac_done = 1'b0;

    // Period 4: underrun before any frame, overrun while done is withheld
    period = PW'(4);
    req_valid = '0;
    req_data[0 +: DW] = 16'h1234;
    do_reset();
    release_rst();
    repeat (3) step();
    chk("und_first", 32'(underrun), 32'(1));
    step();
    chk("und_pulse", 32'(underrun), 32'(0));
    chk("no_hold_before_frame", 32'(dac_start), 32'(0));
    req_valid = 4'b0001;
    wait_ready(20, n);
    chk("p4_first_ready", 32'(cyc - last_rdy), 32'(8));
    chk("p4_ready", 32'(req_ready), 32'b0001);
    req_valid = '0;
    smask = '0;
    omask = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (dac_start) smask |= 32'(1) << k;
      if (overrun)   omask |= 32'(1) << k;
      if (k == 9)  dac_done = 1'b1;
      if (k == 10) dac_done = 1'b0;
    end
    chk("ovr_start_mask", smask, 32'h0000_0002);
    chk("ovr_mask", omask, 32'h0000_0088);
    step();
    chk("und_after_frame", 32'(underrun), 32'(1));
    chk("und_no_ovr", 32'(overrun), 32'(0));
    step();
`ifdef DAC_SCHED_HOLD_EN
    chk("hold_start", 32'(dac_start), 32'(1));
    chk("hold_gid", 32'(grant_id), 32'(0));
`else
    chk("nohold_start", 32'(dac_start), 32'(0));
`endif
    chk("hold_data", 32'(dac_data), 32'h1234);

    // Period clamp: 0 and 1 both tick every 2 cycles; en=0 freezes ticks
    for (int p = 0; p < 2; p++) begin
      period = PW'(p);
      req_valid = '0;
      do_reset();
      release_rst();
      umask = '0;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (underrun) umask |= 32'(1) << k;
      end
      chk("clamp_mask", umask, 32'h0000_00AA);
      en = 1'b0;
      umask = '0;
      for (int k = 1; k <= 6; k++) begin
        step();
        if (underrun) umask |= 32'(1) << k;
      end
      chk("en_off_mask", umask, 32'h0);
      en = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got %0d expected %0d", cyc, 0);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/dac_share_sched.md
DAC_SHARE_SCHED -- requirements
Module: dac_share_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of sample requesters (2..8).
REQ-002 SHALL have parameter DW, default 16, meaning the DAC word width.
REQ-003 SHALL have parameter PW, default 16, meaning the sample-period counter width.
REQ-004 SHALL have port aclk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port areset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  scheduler enable.
REQ-007 SHALL have port period  input  PW  sample period in aclk cycles.
REQ-008 SHALL have port req_valid  input  NREQ  per-requester sample valid.
REQ-009 SHALL have port req_data  input  NREQ*DW  per-requester sample, with requester i occupying bits [i*DW +: DW].
REQ-010 SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-011 SHALL have port dac_data  output  DW  word presented to the DAC serializer.
REQ-012 SHALL have port dac_start  output  1  one-cycle frame start pulse.
REQ-013 SHALL have port dac_done  input  1  one-cycle frame-complete pulse from the serializer.
REQ-014 SHALL have port grant_id  output  $clog2(NREQ)  requester owning the current/last frame.
REQ-015 SHALL have ports underrun and overrun  output  1 each  one-cycle error pulses.

Function
REQ-016 SHALL run a period counter while en=1, counting 0..P-1 and wrapping, where P=max(period,2), with a one-cycle tick at count P-1.
REQ-017 SHALL hold the period counter while en=0, and SHALL NOT tick in that state.
REQ-018 SHALL implement FSM states IDLE, GRANT, START and WAIT.
REQ-019 IDLE, on tick with any req_valid: SHALL select a requester round-robin starting at last_grant+1 (mod NREQ) and go to GRANT.
REQ-020 GRANT: SHALL assert req_ready[g] for exactly one cycle, register dac_data<=req_data[g] and grant_id<=g, update last_grant<=g, and go to START.
REQ-021 Requesters SHALL hold valid/data until ready; the block SHALL NOT re-check valid in GRANT.
REQ-022 START: SHALL assert dac_start for one cycle and go to WAIT.
REQ-023 WAIT: SHALL go to IDLE on dac_done; dac_data SHALL be stable from START until dac_done.
REQ-024 Frame latency SHALL be: tick at cycle T, req_ready at T+1, dac_start at T+2.
REQ-025 On a tick while state is not IDLE: SHALL pulse overrun, drop the tick, and leave the frame in progress unaffected.
REQ-026 On a tick in IDLE with no req_valid: SHALL pulse underrun (behaviour otherwise per REQ-032/033).
REQ-027 If en falls mid-frame: SHALL complete the frame through WAIT and issue no new grant.
REQ-028 dac_done outside WAIT SHALL be ignored.

Reset
REQ-029 areset_n low SHALL asynchronously clear: state=IDLE, counter=0, req_ready=0, dac_start=0, dac_data=0, grant_id=0, underrun=0, overrun=0.
REQ-030 Reset SHALL set last_grant=NREQ-1 so the first grant goes to requester 0.
REQ-031 Reset mid-frame SHALL abandon the frame; the first tick after reset occurs P cycles after release with en=1.

Configuration
REQ-032 With DAC_SCHED_HOLD_EN defined, an underrun tick in IDLE SHALL go directly to START and re-send the current dac_data/grant_id, provided at least one frame has been sent since reset; otherwise it SHALL only pulse underrun.
REQ-033 Without DAC_SCHED_HOLD_EN, an underrun tick SHALL only pulse underrun and SHALL produce no dac_start.

Structure
REQ-034 Package dac_sched_pkg SHALL hold the FSM state enum typedef and the NREQ/DW defaults.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_grant -> grant index, any).

Verification
REQ-036 Scenario: period=10, req_valid=4'b1111, dac_done 5 cycles after each start -> grants 0,1,2,3,0 at 10-cycle spacing, with dac_start 2 cycles after each tick.
REQ-037 Scenario: only req_valid[2]=1 with data 16'hA5A5 -> req_ready[2] single pulse, dac_data=16'hA5A5, grant_id=2.
REQ-038 Scenario: period=4, dac_done withheld for 8 cycles -> overrun pulses at the dropped ticks, with exactly one dac_start.
REQ-039 Scenario: no valid at a tick after one frame of 16'h1234 -> underrun pulse, plus dac_start with dac_data=16'h1234 only when DAC_SCHED_HOLD_EN is defined.
REQ-040 Scenario: period=0 and period=1 -> tick every 2 cycles.
REQ-041 Scenario: areset_n asserted in WAIT -> all outputs cleared immediately; first post-reset grant goes to requester 0.
